// File: rtl/wb_writeback_stage_pkg.sv
// Shared definitions for the write-back stage:
// datapath widths and FSM state encodings.
package wb_writeback_stage_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WRITE = 2'd1,
    ST_HELD  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_bypass_compare.sv
// Write-enable qualification and same-cycle
// bypass match against the two ID read ports.
module wb_bypass_compare
  import wb_writeback_stage_pkg::*;
#(
  parameter int AW          = REG_ADDR_WIDTH,
  parameter bit R0_WRITABLE = 1'b0
) (
  input  logic          active,
  input  logic          we,
  input  logic [AW-1:0] write_reg,
  input  logic [AW-1:0] read_reg1,
  input  logic [AW-1:0] read_reg2,
  output logic          write_en,
  output logic          fwd1_valid,
  output logic          fwd2_valid
);

  logic weff;

  // register 0 may be hard-wired; gate its writes
  always_comb begin
    weff       = we && (R0_WRITABLE || (write_reg != '0));
    write_en   = active && weff;
    fwd1_valid = write_en && (read_reg1 == write_reg);
    fwd2_valid = write_en && (read_reg2 == write_reg);
  end

endmodule

// File: rtl/wb_writeback_stage.sv
// MEM/WB register, writer FSM, data/dest muxes
// and retired-instruction counter.
module wb_writeback_stage
  import wb_writeback_stage_pkg::*;
#(
  parameter int DW          = DATA_WIDTH,
  parameter int AW          = REG_ADDR_WIDTH,
  parameter int CW          = CNT_WIDTH,
  parameter bit R0_WRITABLE = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inValid,
  output logic          inReady,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] aluResult,
  input  logic [DW-1:0] memData,
  input  logic          MemToReg,
  input  logic          RegWriteIn,
  input  logic          RegDst,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] readReg1,
  input  logic [AW-1:0] readReg2,
  output logic          RegWrite,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] dataToWrite,
  output logic          fwd1Valid,
  output logic          fwd2Valid,
  output logic [DW-1:0] fwdData,
  output logic [CW-1:0] retiredCount
);

  wb_state_e     st_q, st_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic occupied;
  logic in_write;
  logic capture;

  assign in_write = (st_q == ST_WRITE);
  assign occupied = in_write || (st_q == ST_HELD);
  assign capture  = !stall && !flush && inValid;

  // next state, entry capture and retire count
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    we_d   = we_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q + {{(CW-1){1'b0}}, in_write};
    if (flush) begin
      st_d = ST_EMPTY;
    end else if (stall) begin
      st_d = occupied ? ST_HELD : ST_EMPTY;
    end else if (inValid) begin
      st_d = ST_WRITE;
    end else begin
      st_d = ST_EMPTY;
    end
    if (capture) begin
      data_d = MemToReg ? memData : aluResult;
      we_d   = RegWriteIn;
      dst_d  = RegDst ? rd : rt;
    end
  end

  // state and pipeline registers, sync reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q   <= ST_EMPTY;
      data_q <= '0;
      we_q   <= 1'b0;
      dst_q  <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      we_q   <= we_d;
      dst_q  <= dst_d;
      cnt_q  <= cnt_d;
    end
  end

  assign inReady      = !stall;
  assign writeReg     = occupied ? dst_q : '0;
  assign dataToWrite  = occupied ? data_q : '0;
  assign fwdData      = dataToWrite;
  assign retiredCount = cnt_q;

  wb_bypass_compare #(
    .AW          (AW),
    .R0_WRITABLE (R0_WRITABLE)
  ) u_bypass (
    .active     (in_write),
    .we         (we_q),
    .write_reg  (writeReg),
    .read_reg1  (readReg1),
    .read_reg2  (readReg2),
    .write_en   (RegWrite),
    .fwd1_valid (fwd1Valid),
    .fwd2_valid (fwd2Valid)
  );

endmodule
